// File: rtl/mux_n_reg_arbitrado.sv
// mux_n_reg_arbitrado: N-channel valid/ready multiplexer with a single-entry output register.
// Channels are picked either directly by Sel or round-robin among valid channels.
`default_nettype none

module mux_n_reg_arbitrado #(
  parameter int WIDTH = 16,
  parameter int N     = 3,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] Datos,
  input  logic [N-1:0]       Validos,
  output logic [N-1:0]       Listos,
  input  logic [SEL_W-1:0]   Sel,
  input  logic               Modo,
  output logic [WIDTH-1:0]   Salida,
  output logic               Salida_valida,
  output logic [SEL_W-1:0]   Canal,
  input  logic               Acepta,
  output logic               Error
);

  logic [WIDTH-1:0] salida_q, salida_d;
  logic [SEL_W-1:0] canal_q, canal_d;
  logic [SEL_W-1:0] puntero_q, puntero_d;
  logic             valida_q, valida_d;
  logic             error_q, error_d;

  logic             carga;
  logic             hit;
  logic [SEL_W-1:0] gidx;
  logic             sel_ok;

  always_comb begin
    carga  = !valida_q || Acepta;
    sel_ok = (int'(Sel) < N);
    hit    = 1'b0;
    gidx   = '0;
    if (carga) begin
      if (!Modo) begin
        for (int k = 0; k < N; k++) begin
          if (Sel == SEL_W'(k) && Validos[k]) begin
            hit  = 1'b1;
            gidx = SEL_W'(k);
          end
        end
      end else begin
        // Scan backwards so the last match is the nearest channel after puntero.
        for (int i = N; i >= 1; i--) begin
          if (Validos[(int'(puntero_q) + i) % N]) begin
            hit  = 1'b1;
            gidx = SEL_W'((int'(puntero_q) + i) % N);
          end
        end
      end
    end
  end

  always_comb begin
    Listos = '0;
    if (hit && rst_n) Listos[gidx] = 1'b1;
  end

  always_comb begin
    salida_d  = salida_q;
    canal_d   = canal_q;
    puntero_d = puntero_q;
    valida_d  = valida_q;
    error_d   = carga && !Modo && !sel_ok;
    if (hit) begin
      salida_d  = Datos[int'(gidx)*WIDTH +: WIDTH];
      canal_d   = gidx;
      puntero_d = gidx;
      valida_d  = 1'b1;
    end else if (Acepta) begin
      valida_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salida_q  <= '0;
      canal_q   <= '0;
      puntero_q <= SEL_W'(N - 1);
      valida_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      salida_q  <= salida_d;
      canal_q   <= canal_d;
      puntero_q <= puntero_d;
      valida_q  <= valida_d;
      error_q   <= error_d;
    end
  end

  assign Salida        = salida_q;
  assign Canal         = canal_q;
  assign Salida_valida = valida_q;
  assign Error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_reg_arbitrado.sv
// Testbench for mux_n_reg_arbitrado: directed vector table, corner sequences and random traffic.
`default_nettype none

module tb_mux_n_reg_arbitrado;
  localparam int WIDTH = 16;
  localparam int N     = 3;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] Datos;
  logic [N-1:0]       Validos;
  logic [N-1:0]       Listos;
  logic [SEL_W-1:0]   Sel;
  logic               Modo;
  logic [WIDTH-1:0]   Salida;
  logic               Salida_valida;
  logic [SEL_W-1:0]   Canal;
  logic               Acepta;
  logic               Error;

  mux_n_reg_arbitrado #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .Datos(Datos), .Validos(Validos), .Listos(Listos),
    .Sel(Sel), .Modo(Modo), .Salida(Salida), .Salida_valida(Salida_valida),
    .Canal(Canal), .Acepta(Acepta), .Error(Error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_canal;
  int               m_ptr;
  logic             m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_grant(input logic modo, input int sel, input logic [N-1:0] v,
                                   input logic carga, input int ptr);
    if (!carga) return -1;
    if (!modo) begin
      if (sel < N) begin
        if (v[sel]) return sel;
      end
      return -1;
    end
    for (int i = 1; i <= N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_canal = 0; m_ptr = N - 1; m_err = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".valid"}, 32'(Salida_valida), 32'(m_valid));
    chk({tag, ".salida"}, 32'(Salida), 32'(m_data));
    chk({tag, ".canal"}, 32'(Canal), 32'(m_canal));
    chk({tag, ".error"}, 32'(Error), 32'(m_err));
  endtask

  // One clock: apply inputs, check Listos, clock, update model, check registers.
  task automatic drive(input logic modo, input logic [SEL_W-1:0] sel, input logic [N-1:0] v,
                       input logic acep, input logic [N*WIDTH-1:0] d, output logic [N-1:0] lst);
    int   g;
    logic carga;
    Modo = modo; Sel = sel; Validos = v; Acepta = acep; Datos = d;
    #2;
    carga = !m_valid || acep;
    g = ref_grant(modo, int'(sel), v, carga, m_ptr);
    lst = Listos;
    chk("listos", 32'(Listos), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    #1;
    m_err = carga && !modo && (int'(sel) >= N);
    if (g >= 0) begin
      m_valid = 1'b1; m_data = d[g*WIDTH +: WIDTH]; m_canal = g; m_ptr = g;
    end else if (acep) begin
      m_valid = 1'b0;
    end
    chk_outputs("step");
  endtask

  typedef struct {
    logic             modo;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     validos;
    logic             acepta;
    logic [N-1:0]     exp_listos;
    logic             exp_valid;
    logic [SEL_W-1:0] exp_canal;
    logic [WIDTH-1:0] exp_salida;
    logic             exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0]       lst;
    logic [WIDTH-1:0]   held;
    logic [N*WIDTH-1:0] dfix;
    int                 seq[6];

    dfix = {16'hABCD, 16'h1111, 16'h2222};
    vecs[0] = '{1'b0, 2'd2, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 16'hABCD, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 16'h2222, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 3'b101, 1'b1, 3'b000, 1'b0, 2'd0, 16'h2222, 1'b0};
    vecs[3] = '{1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 16'h2222, 1'b1};
    vecs[4] = '{1'b0, 2'd1, 3'b010, 1'b0, 3'b010, 1'b1, 2'd1, 16'h1111, 1'b0};
    vecs[5] = '{1'b0, 2'd3, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1, 16'h1111, 1'b1};

    rst_n = 1'b0; Modo = 1'b0; Sel = '0; Validos = '0; Acepta = 1'b0; Datos = '0;
    model_reset();
    #1;
    chk("reset.listos", 32'(Listos), 32'd0);
    chk_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table, each vector from an empty output register
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'd0, 3'b000, 1'b1, dfix, lst);
      drive(vecs[i].modo, vecs[i].sel, vecs[i].validos, vecs[i].acepta, dfix, lst);
      chk($sformatf("vec%0d.listos", i), 32'(lst), 32'(vecs[i].exp_listos));
      chk($sformatf("vec%0d.valid", i), 32'(Salida_valida), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.canal", i), 32'(Canal), 32'(vecs[i].exp_canal));
      chk($sformatf("vec%0d.salida", i), 32'(Salida), 32'(vecs[i].exp_salida));
      chk($sformatf("vec%0d.error", i), 32'(Error), 32'(vecs[i].exp_err));
    end

    // Round-robin after reset: 0,1,2,0,1,2 at one word per cycle
    rst_n = 1'b0; #1; model_reset(); @(posedge clk); #1 rst_n = 1'b1;
    seq = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd0, 3'b111, 1'b1, dfix, lst);
      chk($sformatf("rr%0d.canal", i), 32'(Canal), 32'(seq[i]));
      chk($sformatf("rr%0d.valid", i), 32'(Salida_valida), 32'd1);
    end

    // Backpressure: held word stays put, nothing granted
    held = Salida;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 3'b111, 1'b0, {$urandom, $urandom}, lst);
      chk("hold.listos", 32'(lst), 32'd0);
      chk("hold.salida", 32'(Salida), 32'(held));
      chk("hold.canal", 32'(Canal), 32'd2);
    end
    drive(1'b1, 2'd0, 3'b111, 1'b1, dfix, lst);
    chk("release.canal", 32'(Canal), 32'd0);
    chk("release.salida", 32'(Salida), 32'h2222);

    // Wrap: puntero=1, only channels 0/1 valid -> channel 0
    drive(1'b0, 2'd1, 3'b010, 1'b1, dfix, lst);
    drive(1'b1, 2'd0, 3'b011, 1'b1, dfix, lst);
    chk("wrap.canal", 32'(Canal), 32'd0);
    drive(1'b1, 2'd0, 3'b111, 1'b1, dfix, lst);
    chk("wrap.next", 32'(Canal), 32'd1);

    // Accept with no grant: valid clears, data holds
    drive(1'b1, 2'd0, 3'b000, 1'b1, dfix, lst);
    chk("drain.valid", 32'(Salida_valida), 32'd0);
    chk("drain.salida", 32'(Salida), 32'h1111);

    // Asynchronous reset mid-stream
    drive(1'b1, 2'd0, 3'b111, 1'b1, dfix, lst);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.salida", 32'(Salida), 32'd0);
    chk("areset.valid", 32'(Salida_valida), 32'd0);
    chk("areset.listos", 32'(Listos), 32'd0);
    chk_outputs("areset");
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b1, 2'd0, 3'b111, 1'b1, dfix, lst);
    chk("postreset.canal", 32'(Canal), 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0),
            {16'($urandom), 16'($urandom), 16'($urandom)}, lst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_n_reg_arbitrado.md
MUX_N_REG_ARBITRADO -- requirements
Module: mux_n_reg_arbitrado

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel.
REQ-002 SHALL have parameter N, default 3, channel count, legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = clog2(N), minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Datos  input  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port Validos  input  N  per-channel valid.
REQ-008 SHALL have port Listos  output  N  per-channel ready, combinational, one-hot or zero.
REQ-009 SHALL have port Sel  input  SEL_W  channel index used in Modo 0.
REQ-010 SHALL have port Modo  input  1  0 = direct select by Sel, 1 = round-robin among valid channels.
REQ-011 SHALL have port Salida  output  WIDTH  registered selected data.
REQ-012 SHALL have port Salida_valida  output  1  Salida holds an unaccepted word.
REQ-013 SHALL have port Canal  output  SEL_W  index of the channel that produced Salida.
REQ-014 SHALL have port Acepta  input  1  downstream ready.
REQ-015 SHALL have port Error  output  1  registered one-cycle pulse on illegal Sel.

Function
REQ-016 SHALL have a single-entry output register (Salida, Canal, Salida_valida).
REQ-017 SHALL define carga = !Salida_valida || Acepta; a new word loads only when carga=1.
REQ-018 In Modo 0, SHALL grant channel Sel when carga=1, Sel<N and Validos[Sel]=1; else no grant.
REQ-019 In Modo 1, SHALL grant the first channel with Validos=1, searching from puntero+1 upward with wrap N-1 -> 0; puntero itself is searched last.
REQ-020 SHALL drive Listos[g]=1 only for the granted channel g, in the same cycle; all other bits 0.
REQ-021 A transfer SHALL occur when Validos[g] && Listos[g]; next edge: Salida=Datos slice g, Canal=g, Salida_valida=1.
REQ-022 Latency SHALL be exactly 1 cycle from transfer to Salida_valida=1.
REQ-023 SHALL sustain one word per cycle when Acepta=1 continuously (accept and load in the same cycle).
REQ-024 On Salida_valida && Acepta with no grant, Salida_valida SHALL clear next edge; Salida and Canal hold last values.
REQ-025 While Salida_valida=1 and Acepta=0, Salida, Canal, Salida_valida SHALL hold and Listos SHALL be all 0.
REQ-026 puntero (SEL_W bits) SHALL update to g on every grant in either mode; it SHALL not change without a grant.
REQ-027 In Modo 0 with Sel>=N and carga=1, SHALL make no grant and pulse Error=1 for one cycle at the next edge; output register unaffected.
REQ-028 Error SHALL be 0 in Modo 1 and whenever carga=0.
REQ-029 Changes of Modo or Sel SHALL affect only the grant decision of the current cycle, never a held word.
REQ-030 Validos deasserting without a transfer SHALL have no side effect.

Reset
REQ-031 rst_n=0 SHALL immediately force Salida=0, Canal=0, Salida_valida=0, Error=0, puntero=N-1.
REQ-032 During reset Listos SHALL be all 0; a word held at reset assertion SHALL be discarded.
REQ-033 After rst_n rises, the first round-robin search SHALL start at channel 0.

Verification
REQ-034 N=3, Modo=0, Sel=2, Validos=3'b100, Datos[2]=16'hABCD, Acepta=1 -> Listos=3'b100; next cycle Salida=16'hABCD, Canal=2, Salida_valida=1.
REQ-035 Modo=1, Validos=3'b111 held, Acepta=1, after reset -> Canal sequence 0,1,2,0,... one word per cycle.
REQ-036 Word held, Acepta=0 for 4 cycles, Validos=3'b111 -> Listos=0 and Salida stable for 4 cycles; Acepta=1 -> new word loads next edge.
REQ-037 N=3, Modo=0, Sel=3, Validos=3'b111, output empty -> Listos=0, Error=1 for one cycle, Salida_valida stays 0.
REQ-038 Modo=1, puntero=1, Validos=3'b011 -> grant channel 0 (wrap), puntero becomes 0.
REQ-039 rst_n=0 asynchronously mid-stream with Salida_valida=1 -> Salida=0, Salida_valida=0 before next clock edge; after release Modo=1 grants channel 0 first.
